// File: rtl/eth_gen_pkg.sv
// Shared types and constants for the Ethernet test-traffic generator and
// the PRBS16 generator it uses (also intended for the future checker).
package eth_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SEND,
    GAP,
    DONE
  } gen_state_t;

  localparam logic [1:0] MODE_CNT   = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_PRBS  = 2'd2;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: the feedback is
  // the XOR of state bits 0, 2, 3 and 5, shifted in at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] prbs16_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/eth_prbs16.sv
// Free-running 16-bit Fibonacci LFSR with synchronous load. A zero seed is
// replaced by 1 so the register can never lock up in the all-zero state.
module eth_prbs16
  import eth_gen_pkg::*;
(
  input  logic        clk50,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;
  logic [15:0] seed_safe;

  // Next LFSR value: load wins over stepping.
  always_comb begin
    seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;
    state_d   = state_q;
    if (load) begin
      state_d = seed_safe;
    end else if (enable) begin
      state_d = prbs16_next(state_q);
    end
  end

  // LFSR register, reset to the seed.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q <= seed_safe;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/eth_packet_gen_ex.sv
// Runtime-configurable RMII test-traffic generator. Feeds the byte interface
// of eth_rmii_tx (tx_packet/tx_data out, tx_advance/tx_busy in) with packets
// whose count, length sweep, payload, sequence header and gap are latched
// from cfg_* at start.
//
// state | meaning
// IDLE  | waiting for start after reset
// WAIT  | waiting for the transmitter to go idle before the next packet
// SEND  | packet in flight, one byte per tx_advance
// GAP   | waiting for tx_busy low, then counting the inter-packet gap
// DONE  | run finished (count reached or stopped); start restarts
module eth_packet_gen_ex
  import eth_gen_pkg::*;
#(
  parameter int          CW        = 16,
  parameter int          LW        = 12,
  parameter int          GW        = 16,
  parameter logic [15:0] PRBS_SEED = 16'hACE1
) (
  input  logic          clk50,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] cfg_count,
  input  logic [LW-1:0] cfg_len_min,
  input  logic [LW-1:0] cfg_len_max,
  input  logic [LW-1:0] cfg_len_step,
  input  logic [GW-1:0] cfg_gap,
  input  logic [1:0]    cfg_mode,
  input  logic [7:0]    cfg_const,
  input  logic          cfg_seq_en,
  output logic [7:0]    tx_data,
  output logic          tx_packet,
  input  logic          tx_busy,
  input  logic          tx_advance,
  output logic          active,
  output logic          done,
  output logic [CW-1:0] sent_count
);

  gen_state_t    state_q, state_d;

  // Shadow copy of the configuration taken at start.
  logic [CW-1:0] cnt_cfg_q, cnt_cfg_d;
  logic [LW-1:0] len_min_q, len_min_d;
  logic [LW-1:0] len_max_q, len_max_d;
  logic [LW-1:0] len_step_q, len_step_d;
  logic [GW-1:0] gap_cfg_q, gap_cfg_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    const_q, const_d;
  logic          seq_en_q, seq_en_d;

  // Run-time state.
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [15:0]   seq_q, seq_d;
  logic [CW-1:0] sent_count_q, sent_count_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          gap_armed_q, gap_armed_d;
  logic          stop_pend_q, stop_pend_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_packet_q, tx_packet_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  // PRBS interface and derived values.
  logic          prbs_en, prbs_load;
  logic [15:0]   prbs_q, prbs_nxt;
  logic [LW-1:0] min_adj, max_adj, len_next, idx_inc;
  logic [LW:0]   len_sum;
  logic          stop_now, hdr_byte, last_byte, count_done;

  eth_prbs16 u_prbs (
    .clk50  (clk50),
    .reset  (reset),
    .enable (prbs_en),
    .load   (prbs_load),
    .seed   (PRBS_SEED),
    .state  (prbs_q)
  );

  // Byte value at a given index. The sequence header only replaces indices
  // 0 and 1; the counter payload keeps counting through it.
  function automatic logic [7:0] byte_at(input logic [LW-1:0] idx,
                                         input logic [7:0]    prbs_byte);
    logic [7:0] b;
    if (seq_en_q && idx == '0) begin
      b = seq_q[15:8];
    end else if (seq_en_q && idx == LW'(1)) begin
      b = seq_q[7:0];
    end else begin
      case (mode_q)
        MODE_CONST: b = const_q;
        MODE_PRBS:  b = prbs_byte;
        default:    b = idx[7:0];
      endcase
    end
    return b;
  endfunction

  // Start-time length clamps, sweep arithmetic and per-cycle conditions.
  always_comb begin
    min_adj    = (cfg_len_min == '0) ? LW'(1) : cfg_len_min;
    max_adj    = (cfg_len_max < min_adj) ? min_adj : cfg_len_max;
    // One extra bit so an overflowing sum compares as larger than any max.
    len_sum    = {1'b0, len_q} + {1'b0, len_step_q};
    len_next   = (len_sum > {1'b0, len_max_q}) ? len_min_q : len_sum[LW-1:0];
    idx_inc    = idx_q + LW'(1);
    hdr_byte   = seq_en_q && (idx_q < LW'(2));
    last_byte  = (idx_q == len_q - LW'(1));
    count_done = (cnt_cfg_q != '0) && (sent_count_q == cnt_cfg_q);
    stop_now   = stop | stop_pend_q;
    prbs_nxt   = prbs16_next(prbs_q);
  end

  // Sequencer next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_cfg_d    = cnt_cfg_q;
    len_min_d    = len_min_q;
    len_max_d    = len_max_q;
    len_step_d   = len_step_q;
    gap_cfg_d    = gap_cfg_q;
    mode_d       = mode_q;
    const_d      = const_q;
    seq_en_d     = seq_en_q;
    len_d        = len_q;
    idx_d        = idx_q;
    seq_d        = seq_q;
    sent_count_d = sent_count_q;
    gap_cnt_d    = gap_cnt_q;
    gap_armed_d  = gap_armed_q;
    stop_pend_d  = stop_pend_q;
    tx_data_d    = tx_data_q;
    tx_packet_d  = tx_packet_q;
    active_d     = active_q;
    done_d       = done_q;
    prbs_en      = 1'b0;
    prbs_load    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // A simultaneous stop cancels the start outright.
        if (start && !stop) begin
          cnt_cfg_d    = cfg_count;
          len_min_d    = min_adj;
          len_max_d    = max_adj;
          len_step_d   = cfg_len_step;
          gap_cfg_d    = cfg_gap;
          mode_d       = cfg_mode;
          const_d      = cfg_const;
          seq_en_d     = cfg_seq_en;
          len_d        = min_adj;
          seq_d        = 16'h0000;
          sent_count_d = '0;
          stop_pend_d  = 1'b0;
          done_d       = 1'b0;
          active_d     = 1'b1;
          prbs_load    = 1'b1;
          state_d      = WAIT;
        end
      end

      WAIT: begin
        if (stop_now) begin
          stop_pend_d = 1'b0;
          active_d    = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end else if (!tx_busy) begin
          if (count_done) begin
            active_d = 1'b0;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            idx_d       = '0;
            tx_data_d   = byte_at('0, prbs_q[7:0]);
            tx_packet_d = 1'b1;
            state_d     = SEND;
          end
        end
      end

      SEND: begin
        stop_pend_d = stop_now;
        if (tx_advance) begin
          prbs_en = !hdr_byte;
          if (last_byte) begin
            tx_packet_d  = 1'b0;
            sent_count_d = (sent_count_q == '1) ? sent_count_q
                                                : sent_count_q + CW'(1);
            seq_d        = seq_q + 16'd1;
            len_d        = len_next;
            if (stop_now) begin
              stop_pend_d = 1'b0;
              active_d    = 1'b0;
              done_d      = 1'b1;
              state_d     = DONE;
            end else begin
              gap_cnt_d   = gap_cfg_q;
              gap_armed_d = 1'b0;
              state_d     = GAP;
            end
          end else begin
            // Look ahead so tx_data reflects the new index one cycle later.
            idx_d     = idx_inc;
            tx_data_d = byte_at(idx_inc, hdr_byte ? prbs_q[7:0] : prbs_nxt[7:0]);
          end
        end
      end

      GAP: begin
        if (stop_now) begin
          stop_pend_d = 1'b0;
          active_d    = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end else if (!gap_armed_q) begin
          if (!tx_busy) begin
            if (gap_cnt_q == '0) begin
              state_d = WAIT;
            end else begin
              gap_armed_d = 1'b1;
            end
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
          if (gap_cnt_q == GW'(1)) begin
            gap_armed_d = 1'b0;
            state_d     = WAIT;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_cfg_q    <= '0;
      len_min_q    <= '0;
      len_max_q    <= '0;
      len_step_q   <= '0;
      gap_cfg_q    <= '0;
      mode_q       <= MODE_CNT;
      const_q      <= 8'h00;
      seq_en_q     <= 1'b0;
      len_q        <= '0;
      idx_q        <= '0;
      seq_q        <= 16'h0000;
      sent_count_q <= '0;
      gap_cnt_q    <= '0;
      gap_armed_q  <= 1'b0;
      stop_pend_q  <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_packet_q  <= 1'b0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_cfg_q    <= cnt_cfg_d;
      len_min_q    <= len_min_d;
      len_max_q    <= len_max_d;
      len_step_q   <= len_step_d;
      gap_cfg_q    <= gap_cfg_d;
      mode_q       <= mode_d;
      const_q      <= const_d;
      seq_en_q     <= seq_en_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      seq_q        <= seq_d;
      sent_count_q <= sent_count_d;
      gap_cnt_q    <= gap_cnt_d;
      gap_armed_q  <= gap_armed_d;
      stop_pend_q  <= stop_pend_d;
      tx_data_q    <= tx_data_d;
      tx_packet_q  <= tx_packet_d;
      active_q     <= active_d;
      done_q       <= done_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_packet  = tx_packet_q;
  assign active     = active_q;
  assign done       = done_q;
  assign sent_count = sent_count_q;

endmodule

// File: tb/tb_eth_packet_gen_ex.sv
// Bench for eth_packet_gen_ex: a stub transmitter consumes bytes and records
// packets; a reference model builds the expected packet list from the
// configuration rules.
module tb_eth_packet_gen_ex;

  localparam int          CW   = 16;
  localparam int          LW   = 12;
  localparam int          GW   = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk50 = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic [CW-1:0] cfg_count    = '0;
  logic [LW-1:0] cfg_len_min  = '0;
  logic [LW-1:0] cfg_len_max  = '0;
  logic [LW-1:0] cfg_len_step = '0;
  logic [GW-1:0] cfg_gap      = '0;
  logic [1:0]    cfg_mode     = '0;
  logic [7:0]    cfg_const    = '0;
  logic          cfg_seq_en   = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_packet;
  logic          tx_busy    = 1'b0;
  logic          tx_advance = 1'b0;
  logic          active;
  logic          done;
  logic [CW-1:0] sent_count;

  always #10 clk50 = ~clk50;

  eth_packet_gen_ex #(.CW(CW), .LW(LW), .GW(GW), .PRBS_SEED(SEED)) dut (
    .clk50        (clk50),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .cfg_count    (cfg_count),
    .cfg_len_min  (cfg_len_min),
    .cfg_len_max  (cfg_len_max),
    .cfg_len_step (cfg_len_step),
    .cfg_gap      (cfg_gap),
    .cfg_mode     (cfg_mode),
    .cfg_const    (cfg_const),
    .cfg_seq_en   (cfg_seq_en),
    .tx_data      (tx_data),
    .tx_packet    (tx_packet),
    .tx_busy      (tx_busy),
    .tx_advance   (tx_advance),
    .active       (active),
    .done         (done),
    .sent_count   (sent_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Model configuration for the current run.
  int c_count, c_min, c_max, c_step, c_gap, c_mode, c_const;
  bit c_seq;
  int adv_period = 4;

  logic [7:0] got_bytes[$];
  int         got_lens[$];
  int         gaps[$];
  logic [7:0] exp_bytes[$];
  int         exp_lens[$];

  // Stub transmitter: busy during a packet plus a short tail, one advance
  // every adv_period cycles, capturing each byte as it is consumed.
  int div = 0, busy_tail = 0, idle_cnt = 0, cur_len = 0;
  bit prev_pkt = 1'b0;
  always @(negedge clk50) begin
    if (tx_packet) begin
      if (!prev_pkt) begin
        if (got_lens.size() > 0) gaps.push_back(idle_cnt);
        idle_cnt = 0;
        cur_len  = 0;
        div      = 0;
      end
      busy_tail = 3;
      tx_busy   = 1'b1;
      if (div >= adv_period - 1) begin
        tx_advance = 1'b1;
        got_bytes.push_back(tx_data);
        cur_len++;
        div = 0;
      end else begin
        tx_advance = 1'b0;
        div++;
      end
    end else begin
      tx_advance = 1'b0;
      div = 0;
      if (prev_pkt) got_lens.push_back(cur_len);
      if (busy_tail > 0) begin
        busy_tail--;
        tx_busy = 1'b1;
      end else begin
        tx_busy = 1'b0;
      end
      if (!tx_busy) idle_cnt++;
    end
    prev_pkt = tx_packet;
  end

  // Expected packets of a run: lengths from the sweep rules, bytes from the
  // header/payload rules, PRBS kept as an integer LFSR reseeded per run.
  task automatic build_expected(input int n);
    int mn, mx, cur, b, fb;
    int lfsr;
    exp_bytes.delete();
    exp_lens.delete();
    mn   = (c_min == 0) ? 1 : c_min;
    mx   = (c_max < mn) ? mn : c_max;
    cur  = mn;
    lfsr = (SEED == 16'h0000) ? 1 : int'(SEED);
    for (int k = 0; k < n; k++) begin
      exp_lens.push_back(cur);
      for (int i = 0; i < cur; i++) begin
        if (c_seq && i == 0) begin
          b = (k >> 8) & 255;
        end else if (c_seq && i == 1) begin
          b = k & 255;
        end else if (c_mode == 1) begin
          b = c_const;
        end else if (c_mode == 2) begin
          b    = lfsr & 255;
          fb   = (lfsr ^ (lfsr >> 2) ^ (lfsr >> 3) ^ (lfsr >> 5)) & 1;
          lfsr = (lfsr >> 1) | (fb << 15);
        end else begin
          b = i & 255;
        end
        exp_bytes.push_back(8'(b));
      end
      cur = cur + c_step;
      if (cur > mx) cur = mn;
    end
  endtask

  task automatic start_run();
    @(negedge clk50);
    got_bytes.delete();
    got_lens.delete();
    gaps.delete();
    cfg_count    = CW'(c_count);
    cfg_len_min  = LW'(c_min);
    cfg_len_max  = LW'(c_max);
    cfg_len_step = LW'(c_step);
    cfg_gap      = GW'(c_gap);
    cfg_mode     = 2'(c_mode);
    cfg_const    = 8'(c_const);
    cfg_seq_en   = c_seq;
    start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk50);
    check_eq({tag, " done"}, done, 1);
    repeat (2) @(negedge clk50);
  endtask

  task automatic wait_pkt(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && !(got_lens.size() >= n && tx_packet); i++) @(negedge clk50);
    check_eq({tag, " packet started"}, (got_lens.size() >= n && tx_packet), 1);
  endtask

  task automatic compare_run(input string tag);
    int n, bad, at;
    check_eq({tag, " packet count"}, got_lens.size(), exp_lens.size());
    n = (got_lens.size() < exp_lens.size()) ? got_lens.size() : exp_lens.size();
    for (int k = 0; k < n; k++) check_eq({tag, " length"}, got_lens[k], exp_lens[k]);
    check_eq({tag, " byte total"}, got_bytes.size(), exp_bytes.size());
    if (got_bytes.size() == exp_bytes.size() && exp_bytes.size() > 0) begin
      bad = -1;
      for (int i = 0; i < exp_bytes.size() && bad < 0; i++)
        if (got_bytes[i] !== exp_bytes[i]) bad = i;
      at = (bad >= 0) ? bad : exp_bytes.size() - 1;
      check_eq({tag, " bytes"}, got_bytes[at], exp_bytes[at]);
    end
    check_eq({tag, " sent_count"}, sent_count, exp_lens.size());
    check_eq({tag, " active"}, active, 0);
  endtask

  task automatic do_reset();
    @(negedge clk50);
    reset = 1'b1;
    repeat (3) @(negedge clk50);
    reset = 1'b0;
    repeat (6) @(negedge clk50);
  endtask

  initial begin
    repeat (4) @(negedge clk50);
    check_eq("reset tx_packet", tx_packet, 0);
    check_eq("reset tx_data", tx_data, 0);
    check_eq("reset active", active, 0);
    check_eq("reset done", done, 0);
    check_eq("reset sent_count", sent_count, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk50);

    // Fixed-length counter packets.
    c_count = 3; c_min = 8; c_max = 8; c_step = 0; c_gap = 0;
    c_mode = 0; c_const = 0; c_seq = 0; adv_period = 4;
    build_expected(3);
    start_run();
    wait_done("counter", 5000);
    compare_run("counter");

    // Length sweep 4,7,10,4,7.
    c_count = 5; c_min = 4; c_max = 10; c_step = 3;
    build_expected(5);
    start_run();
    wait_done("sweep", 5000);
    compare_run("sweep");

    // Sequence header over constant payload.
    c_count = 2; c_min = 5; c_max = 5; c_step = 0; c_mode = 1; c_const = 8'hA5; c_seq = 1;
    build_expected(2);
    start_run();
    wait_done("seq const", 5000);
    compare_run("seq const");

    // PRBS, run twice to confirm the restart reproduces the sequence.
    c_count = 2; c_min = 4; c_max = 4; c_mode = 2; c_seq = 0;
    build_expected(2);
    for (int r = 0; r < 2; r++) begin
      start_run();
      wait_done("prbs", 5000);
      compare_run("prbs");
    end

    // Continuous run with gap, a start ignored mid-run, stop in packet 3.
    c_count = 0; c_min = 6; c_max = 6; c_step = 0; c_gap = 20; c_mode = 0; c_seq = 1;
    build_expected(3);
    start_run();
    wait_pkt("continuous p2", 1, 2000);
    cfg_count = CW'(1); cfg_mode = 2'd1; cfg_len_min = LW'(2); cfg_len_max = LW'(2);
    start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
    wait_pkt("continuous p3", 2, 2000);
    repeat (5) @(negedge clk50);
    stop = 1'b1;
    @(negedge clk50);
    stop = 1'b0;
    wait_done("continuous", 3000);
    compare_run("continuous");
    check_eq("gap samples", gaps.size(), 2);
    foreach (gaps[i]) check_eq("gap at least 20", gaps[i] >= 20, 1);

    // Reset in the middle of a packet, then a clean run.
    c_count = 2; c_min = 20; c_max = 20; c_gap = 0; c_seq = 0;
    start_run();
    wait_pkt("abort", 0, 500);
    repeat (10) @(negedge clk50);
    reset = 1'b1;
    @(negedge clk50);
    check_eq("abort tx_packet", tx_packet, 0);
    check_eq("abort active", active, 0);
    check_eq("abort done", done, 0);
    check_eq("abort sent_count", sent_count, 0);
    reset = 1'b0;
    repeat (8) @(negedge clk50);
    c_count = 2; c_min = 3; c_max = 3; c_mode = 1; c_const = 8'h3C; c_seq = 1;
    build_expected(2);
    start_run();
    wait_done("after abort", 3000);
    compare_run("after abort");

    // start and stop together from IDLE.
    do_reset();
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk50);
    start = 1'b0;
    stop  = 1'b0;
    repeat (10) @(negedge clk50);
    check_eq("start+stop active", active, 0);
    check_eq("start+stop done", done, 0);
    check_eq("start+stop tx_packet", tx_packet, 0);

    // Randomised configurations.
    for (int t = 0; t < 8; t++) begin
      c_count    = $urandom_range(1, 5);
      c_min      = $urandom_range(0, 12);
      c_max      = $urandom_range(0, 24);
      c_step     = $urandom_range(0, 6);
      c_gap      = $urandom_range(0, 4);
      c_mode     = $urandom_range(0, 3);
      c_const    = $urandom_range(0, 255);
      c_seq      = 1'($urandom_range(0, 1));
      adv_period = $urandom_range(1, 3);
      build_expected(c_count);
      start_run();
      wait_done("random", 5000);
      compare_run("random");
    end

    // Length sweep whose sum overflows the length width.
    c_count = 3; c_min = 4093; c_max = 4095; c_step = 2; c_gap = 0;
    c_mode = 0; c_seq = 0; adv_period = 1;
    build_expected(3);
    start_run();
    wait_done("overflow", 20000);
    compare_run("overflow");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_packet_gen_ex.md
Name: eth_packet_gen_ex

Overview:
- Parametrised RMII test-traffic generator; successor to the fixed-count, fixed-length, counting-payload generator.
- Produces a byte stream for the existing eth_rmii_tx byte interface (packet/data/advance/busy); a top wrapper connects the two.
- Adds runtime configuration: packet count (including continuous), length sweep, payload mode, optional sequence-number header, inter-packet gap, stop, and status.

Parameters:
- CW, 16, width of packet counters.
- LW, 12, width of packet length fields in bytes.
- GW, 16, width of the inter-packet gap counter in clk50 cycles.
- PRBS_SEED, 16'hACE1, LFSR seed; a seed of zero is replaced by 16'h0001.

Ports:
- clk50  in  1  clock; the block has only this one clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a run.
- stop  in  1  pulse; ends the run after the packet in flight.
- cfg_count  in  CW  packets per run; 0 = continuous.
- cfg_len_min  in  LW  first and minimum packet length.
- cfg_len_max  in  LW  maximum packet length.
- cfg_len_step  in  LW  length increment per packet.
- cfg_gap  in  GW  idle cycles after tx_busy falls, before the next packet.
- cfg_mode  in  2  payload: 0 counter, 1 constant, 2 PRBS16, 3 = counter.
- cfg_const  in  8  byte sent in constant mode.
- cfg_seq_en  in  1  bytes 0-1 carry the 16-bit sequence number, big-endian.
- tx_data  out  8  current byte.
- tx_packet  out  1  packet in progress.
- tx_busy  in  1  transmitter busy (from eth_rmii_tx).
- tx_advance  in  1  pulse: current byte consumed.
- active  out  1  run in progress.
- done  out  1  run complete; sticky until the next start or reset.
- sent_count  out  CW  packets completed in this run; saturates at all-ones.

Behaviour:
- Reset: all outputs 0, state IDLE, tx_packet drops the cycle after reset is sampled, LFSR loaded with seed. Reset mid-packet is a legal abort.
- Config latch, in IDLE or DONE on start:
  - cfg_* copied to shadow registers; live cfg changes have no effect until the next start.
  - cfg_len_min==0 is treated as 1.
  - cfg_len_max<min is treated as max=min.
  - cfg_len_step==0 gives a fixed length.
  - Clears done and sent_count, resets the sequence number to 0, reseeds the LFSR.
  - Sets active.
- start while active is ignored. start and stop in the same cycle: stop wins, the run never starts.
- States:
  - IDLE: waits for start.
  - WAIT: waits for tx_busy==0, then either sets tx_packet, loads the byte index to 0 and goes to SEND, or goes to DONE if the count is exhausted or stop is pending.
  - SEND: each tx_advance increments the byte index, so tx_data updates the cycle after the advance. On tx_advance at index len-1: tx_packet drops, sent_count and sequence number increment, the next length is computed, then go to GAP.
  - GAP: waits for tx_busy==0, then counts cfg_gap cycles. cfg_gap==0 gives no extra cycles. Then go to WAIT.
  - DONE: active=0, done=1; start restarts.
- Byte value at index i:
  - seq_en and i==0: seq[15:8]; seq_en and i==1: seq[7:0]. These override payload bytes only when len>=2; when len==1 only seq[15:8] is sent.
  - Otherwise by mode: counter = i[7:0] (the index keeps counting through the header); constant = cfg_const; PRBS = LFSR[7:0].
  - LFSR: Fibonacci x^16+x^14+x^13+x^11+1. Steps once per payload tx_advance and free-runs across packets within a run.
- Length sweep:
  - next = cur+step; if next>max or the addition overflows LW bits, next = min.
  - The comparison is done LW+1 bits wide.
- Count: finite runs send exactly cfg_count packets. Continuous runs end only on stop or reset.
- stop:
  - Latched as stop_pend.
  - In SEND the current packet completes normally, including its length, then DONE; no GAP.
  - In WAIT or GAP: go straight to DONE.
  - tx_packet never drops early.
- tx_advance outside SEND is ignored.
- tx_data holds its value when tx_packet==0.

Decomposition:
- Package eth_gen_pkg: gen_state_t enum (IDLE, WAIT, SEND, GAP, DONE), payload mode constants (MODE_CNT, MODE_CONST, MODE_PRBS), LFSR tap mask constant.
- Sub-module eth_prbs16: enable, load, seed inputs; 16-bit state output. Reusable by the future checker.

Test Plan:
- cfg_count=3, min=max=8, mode 0, seq off, gap 0, stub tx advancing every 4 cycles -> 3 packets of 00..07; done=1 and sent_count=3.
- min=4, max=10, step=3, count=5 -> lengths 4,7,10,4,7.
- seq_en=1, mode 1, const=A5, len 5, count 2 -> 00 00 A5 A5 A5, then 00 01 A5 A5 A5.
- mode 2, seed ACE1, len 4 -> bytes match the reference-model LFSR; the next packet continues the same sequence; a restart reproduces the first packet exactly.
- count=0, gap=20, stop pulsed mid-packet 3 -> packet 3 completes at full length; done=1, sent_count=3; >=20 idle cycles measured between packets after busy falls.
- reset asserted mid-SEND -> tx_packet=0 the next cycle; active, done, sent_count=0; a new start runs normally. Also check: start during a run is ignored; start and stop together leave the block in IDLE.
